// File: rtl/rate_limiter_core.sv
// rate_limiter_core: token-bucket rate limiter on an AXI4-Stream packet path.
// Packet starts are gated on a non-negative byte-credit bucket; once a packet
// has started it always runs to completion, driving the bucket negative if
// needed. The handshake path is purely combinational (zero added latency).
module rate_limiter_core #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                                axi_aclk,
    input  logic                                reset,

    input  logic [C_M_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                                s_axis_tvalid,
    input  logic                                s_axis_tlast,
    output logic                                s_axis_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    input  logic                                m_axis_tready,

    input  logic                                cfg_enable,
    input  logic [31:0]                         cfg_tick_period,
    input  logic [31:0]                         cfg_tokens_inc,
    input  logic [31:0]                         cfg_bucket_max,

    output logic [C_S_AXI_DATA_WIDTH-1:0]       stat_pkt_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       stat_throttle_cycles
);

    localparam int KEEP_W = C_M_AXIS_DATA_WIDTH / 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PASS = 1'b1;

    logic [0:0]                    state_q, state_d;
    logic signed [33:0]            bucket_q, bucket_d;
    logic [31:0]                   tick_cnt_q, tick_cnt_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] thr_cnt_q, thr_cnt_d;

    logic               tick;
    logic               gate_open;
    logic               accept;
    logic signed [33:0] debit;
    logic signed [33:0] inc_ext;
    logic signed [33:0] max_ext;
    logic signed [33:0] bucket_sum;

    // Gate and zero-latency handshake; reset forces both valid and ready low
    always_comb begin
        gate_open     = !reset &&
                        ((state_q == ST_PASS) || !bucket_q[33] || !cfg_enable);
        m_axis_tvalid = s_axis_tvalid & gate_open;
        s_axis_tready = m_axis_tready & gate_open;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tkeep  = s_axis_tkeep;
        m_axis_tuser  = s_axis_tuser;
        m_axis_tlast  = s_axis_tlast;
        accept        = s_axis_tvalid & s_axis_tready;
    end

    // Refill tick: counter wraps to 0 on reaching the programmed period
    always_comb begin
        tick       = (tick_cnt_q >= cfg_tick_period);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 32'd1;
    end

    // Bucket update: credit and debit both land in the same cycle, then clamp
    always_comb begin
        debit = '0;
        if (accept) begin
            for (int unsigned i = 0; i < KEEP_W; i++) begin
                debit = debit + 34'(s_axis_tkeep[i]);
            end
        end
        inc_ext    = tick ? $signed({2'b00, cfg_tokens_inc}) : '0;
        max_ext    = $signed({2'b00, cfg_bucket_max});
        bucket_sum = bucket_q + inc_ext - debit;
        if (!cfg_enable) begin
            bucket_d = max_ext;
        end else if (bucket_sum > max_ext) begin
            bucket_d = max_ext;
        end else begin
            bucket_d = bucket_sum;
        end
    end

    // Packet framing FSM: any accepted beat decides in/out of packet by tlast
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = s_axis_tlast ? ST_IDLE : ST_PASS;
        end
    end

    // Statistics: forwarded packets and cycles a packet start was held back
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        thr_cnt_d = thr_cnt_q;
        if (accept && s_axis_tlast) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end
        if ((state_q == ST_IDLE) && s_axis_tvalid && !gate_open) begin
            thr_cnt_d = thr_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bucket_q   <= '0;
            tick_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            thr_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            bucket_q   <= bucket_d;
            tick_cnt_q <= tick_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            thr_cnt_q  <= thr_cnt_d;
        end
    end

    assign stat_pkt_count       = pkt_cnt_q;
    assign stat_throttle_cycles = thr_cnt_q;

endmodule

// File: tb/tb_rate_limiter_core.sv
// Testbench for rate_limiter_core: single-cycle vector table plus directed
// multi-cycle sequences for tick timing, saturation, enable toggling and reset.
module tb_rate_limiter_core;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          cfg_enable;
    logic [31:0]   cfg_tick_period;
    logic [31:0]   cfg_tokens_inc;
    logic [31:0]   cfg_bucket_max;
    logic [31:0]   stat_pkt_count;
    logic [31:0]   stat_throttle_cycles;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rate_limiter_core #(
        .C_M_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .C_S_AXI_DATA_WIDTH  (32)
    ) dut (
        .axi_aclk            (clk),
        .reset               (reset),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tkeep        (s_axis_tkeep),
        .s_axis_tuser        (s_axis_tuser),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tlast        (s_axis_tlast),
        .s_axis_tready       (s_axis_tready),
        .m_axis_tdata        (m_axis_tdata),
        .m_axis_tkeep        (m_axis_tkeep),
        .m_axis_tuser        (m_axis_tuser),
        .m_axis_tvalid       (m_axis_tvalid),
        .m_axis_tlast        (m_axis_tlast),
        .m_axis_tready       (m_axis_tready),
        .cfg_enable          (cfg_enable),
        .cfg_tick_period     (cfg_tick_period),
        .cfg_tokens_inc      (cfg_tokens_inc),
        .cfg_bucket_max      (cfg_bucket_max),
        .stat_pkt_count      (stat_pkt_count),
        .stat_throttle_cycles(stat_throttle_cycles)
    );

    typedef struct {
        logic        en;
        logic        v;
        logic        r;
        logic        last;
        logic [31:0] keep;
        logic        exp_mv;
        logic        exp_sr;
        longint      exp_bkt;
        int          exp_pkt;
        int          exp_thr;
    } vec_t;

    vec_t tbl [10];

    function automatic vec_t mk(input logic en, input logic v, input logic r,
                                input logic last, input logic [31:0] keep,
                                input logic exp_mv, input logic exp_sr,
                                input longint exp_bkt, input int exp_pkt,
                                input int exp_thr);
        vec_t t;
        t.en = en; t.v = v; t.r = r; t.last = last; t.keep = keep;
        t.exp_mv = exp_mv; t.exp_sr = exp_sr; t.exp_bkt = exp_bkt;
        t.exp_pkt = exp_pkt; t.exp_thr = exp_thr;
        return t;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint bkt();
        return longint'($signed(dut.bucket_q));
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic last, input logic [31:0] keep);
        s_axis_tvalid = v;
        s_axis_tlast  = last;
        s_axis_tkeep  = keep;
        s_axis_tdata  = {8{$urandom}};
        s_axis_tuser  = {4{$urandom}};
    endtask

    task automatic set_cfg(input logic en, input logic [31:0] per,
                           input logic [31:0] inc, input logic [31:0] mx);
        cfg_enable      = en;
        cfg_tick_period = per;
        cfg_tokens_inc  = inc;
        cfg_bucket_max  = mx;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, '0);
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int held;
        int stall;
        int bad;
        int beat;
        int cycles;
        logic acc;

        reset         = 1'b1;
        m_axis_tready = 1'b1;
        set_cfg(1'b1, 32'd1000, 32'd0, 32'd1024);
        drive(1'b1, 1'b0, '1);
        #1;

        // Reset: handshake low, state cleared
        check("rst_mvalid", m_axis_tvalid, 0);
        check("rst_sready", s_axis_tready, 0);
        cyc();
        cyc();
        check("rst_pkt", stat_pkt_count, 0);
        check("rst_thr", stat_throttle_cycles, 0);
        check("rst_bkt", bkt(), 0);
        drive(1'b0, 1'b0, '0);
        reset = 1'b0;

        // Single-cycle vectors from bucket=0, IDLE, no ticks, inc=0, max=1024
        tbl[0] = mk(1, 0, 1, 0, 32'hFFFF_FFFF, 0, 1,    0, 0, 0);
        tbl[1] = mk(1, 1, 0, 0, 32'hFFFF_FFFF, 1, 0,    0, 0, 0);
        tbl[2] = mk(1, 1, 1, 0, 32'hFFFF_FFFF, 1, 1,  -32, 0, 0);
        tbl[3] = mk(1, 1, 0, 0, 32'hFFFF_FFFF, 1, 0,  -32, 0, 0);
        tbl[4] = mk(1, 1, 1, 1, 32'h0000_FFFF, 1, 1,  -48, 1, 0);
        tbl[5] = mk(1, 1, 1, 1, 32'h0000_000F, 0, 0,  -48, 1, 1);
        tbl[6] = mk(1, 1, 0, 1, 32'h0000_000F, 0, 0,  -48, 1, 2);
        tbl[7] = mk(1, 0, 1, 0, 32'h0000_000F, 0, 0,  -48, 1, 2);
        tbl[8] = mk(0, 1, 1, 1, 32'h0000_000F, 1, 1, 1024, 2, 2);
        tbl[9] = mk(1, 0, 1, 0, 32'h0000_000F, 0, 1, 1024, 2, 2);

        for (int i = 0; i < 10; i++) begin
            cfg_enable    = tbl[i].en;
            m_axis_tready = tbl[i].r;
            drive(tbl[i].v, tbl[i].last, tbl[i].keep);
            #3;
            check($sformatf("vec%0d_mvalid", i), m_axis_tvalid, tbl[i].exp_mv);
            check($sformatf("vec%0d_sready", i), s_axis_tready, tbl[i].exp_sr);
            check($sformatf("vec%0d_passthru", i),
                  (m_axis_tdata === s_axis_tdata && m_axis_tkeep === s_axis_tkeep &&
                   m_axis_tuser === s_axis_tuser && m_axis_tlast === s_axis_tlast), 1);
            cyc();
            check($sformatf("vec%0d_bucket", i), bkt(), tbl[i].exp_bkt);
            check($sformatf("vec%0d_pkt", i), stat_pkt_count, tbl[i].exp_pkt);
            check($sformatf("vec%0d_thr", i), stat_throttle_cycles, tbl[i].exp_thr);
        end

        // 64B packet drains bucket to -64; next start waits for two ticks
        set_cfg(1'b1, 32'd9, 32'd32, 32'd1024);
        m_axis_tready = 1'b1;
        do_reset();
        drive(1'b1, 1'b0, '1);
        cyc();
        drive(1'b1, 1'b1, '1);
        cyc();
        check("p64_bucket", bkt(), -64);
        check("p64_pkt", stat_pkt_count, 1);
        drive(1'b1, 1'b1, 32'h0000_000F);
        held = 0;
        while (s_axis_tready !== 1'b1 && held < 100) begin
            cyc();
            held++;
        end
        check("p64_held_cycles", held, 18);
        check("p64_thr", stat_throttle_cycles, 18);
        cyc();
        drive(1'b0, 1'b0, '0);
        check("p64_bucket_after", bkt(), -4);
        check("p64_pkt_after", stat_pkt_count, 2);

        // Period 0: tick every cycle; tick and debit land together (+32-4)
        set_cfg(1'b1, 32'd0, 32'd32, 32'd1024);
        do_reset();
        cyc();
        check("per0_bucket", bkt(), 32);
        drive(1'b1, 1'b1, 32'h0000_000F);
        cyc();
        drive(1'b0, 1'b0, '0);
        check("tick_debit_bucket", bkt(), 60);

        // Saturation at the ceiling
        cfg_enable = 1'b0;
        cyc();
        check("dis_load_max", bkt(), 1024);
        cfg_enable     = 1'b1;
        cfg_tokens_inc = 32'd0;
        drive(1'b1, 1'b1, 32'h0000_000F);
        cyc();
        drive(1'b0, 1'b0, '0);
        check("bucket_1020", bkt(), 1020);
        cfg_tokens_inc = 32'd32;
        cyc();
        check("sat_1024", bkt(), 1024);
        cfg_bucket_max = 32'd1000;
        cyc();
        check("sat_new_max", bkt(), 1000);

        // Enable toggled mid-packet with bucket negative: no beat held
        set_cfg(1'b1, 32'd1000, 32'd0, 32'd0);
        do_reset();
        stall = 0;
        for (int i = 1; i <= 10; i++) begin
            cfg_enable = !(i == 4 || i == 5);
            drive(1'b1, (i == 10), '1);
            #1;
            if (s_axis_tready !== 1'b1) stall++;
            cyc();
        end
        cfg_enable = 1'b1;
        check("toggle_stalls", stall, 0);
        check("toggle_bucket", bkt(), -160);
        check("toggle_pkt", stat_pkt_count, 1);
        drive(1'b1, 1'b1, 32'h0000_000F);
        #1;
        check("toggle_next_sready", s_axis_tready, 0);
        check("toggle_next_mvalid", m_axis_tvalid, 0);
        cyc();
        check("toggle_next_thr", stat_throttle_cycles, 1);

        // Reset pulse after beat 3 of 5 abandons the packet
        cfg_enable = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, '1);
            cyc();
        end
        reset = 1'b1;
        drive(1'b1, 1'b0, '1);
        #1;
        check("midrst_mvalid", m_axis_tvalid, 0);
        check("midrst_sready", s_axis_tready, 0);
        cyc();
        reset      = 1'b0;
        cfg_enable = 1'b1;
        check("midrst_pkt", stat_pkt_count, 0);
        check("midrst_thr", stat_throttle_cycles, 0);
        check("midrst_bucket", bkt(), 0);
        drive(1'b1, 1'b0, '1);
        #1;
        check("midrst_b4_sready", s_axis_tready, 1);
        cyc();
        check("midrst_b4_bucket", bkt(), -32);
        drive(1'b1, 1'b1, '1);
        #1;
        check("midrst_b5_sready", s_axis_tready, 1);
        cyc();
        drive(1'b0, 1'b0, '0);
        check("midrst_b5_pkt", stat_pkt_count, 1);
        check("midrst_b5_bucket", bkt(), -64);

        // Disabled: two back-to-back 1500B packets with random downstream stalls
        set_cfg(1'b0, 32'd9, 32'd32, 32'd1024);
        do_reset();
        bad    = 0;
        beat   = 0;
        cycles = 0;
        while (beat < 94 && cycles < 400) begin
            drive(1'b1, (beat % 47 == 46), (beat % 47 == 46) ? 32'h0FFF_FFFF : 32'hFFFF_FFFF);
            m_axis_tready = ($urandom_range(0, 3) != 0);
            #1;
            if (s_axis_tready !== m_axis_tready || m_axis_tvalid !== 1'b1) bad++;
            acc = s_axis_tready;
            cyc();
            if (acc) beat++;
            cycles++;
        end
        drive(1'b0, 1'b0, '0);
        m_axis_tready = 1'b1;
        check("dis_handshake_errs", bad, 0);
        check("dis_beats", beat, 94);
        check("dis_pkt", stat_pkt_count, 2);
        check("dis_thr", stat_throttle_cycles, 0);
        check("dis_bucket", bkt(), 1024);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
